spi_slave_9952: RTL and testbench
=================================

// Module: spi_slave_9952
// PURPOSE
//  SPI responder emulating the AD9952 DDS serial port and register file; the target side of the 9952 master link.
//  Receives instruction + data bytes on sclk/n_cs/mosi into shadow registers and returns reads on miso.
//  Copies shadow to active registers on io_update. Used as a board-level DDS stand-in and as the loop-back target in master benches.
// PARAMETERS
//  SYNC_STAGES  2            synchronizer depth on sclk, n_cs, mosi, io_update (>=2)
//  CFR2_RST     24'h000018   reset value of CFR2 (shadow and active); all other registers reset to 0
// PORTS
//  clk        in   1   system clock; sclk half-period >= SYNC_STAGES+1 clk periods
//  n_rst      in   1   asynchronous, active-low reset
//  sclk       in   1   SPI clock from master, idle low, mode 0
//  n_cs       in   1   chip select, active low
//  mosi       in   1   serial data in, MSB first
//  io_update  in   1   shadow->active transfer strobe (rising edge)
//  miso       out  1   serial read data
//  miso_oe    out  1   high while miso carries read data
//  cfr1_o     out  32  active CFR1 (addr 0)
//  cfr2_o     out  24  active CFR2 (addr 1)
//  asf_o      out  16  active ASF (addr 2)
//  arr_o      out  8   active ARR (addr 3)
//  ftw_o      out  32  active FTW0 (addr 4)
//  pow_o      out  16  active POW0 (addr 5)
//  upd_p      out  1   1-clk pulse when active registers were loaded
//  err_p      out  1   1-clk pulse on instruction with addr > 5
// BEHAVIOUR
//  Reset: miso=0, miso_oe=0, upd_p=0, err_p=0. Shadow = active = reset values. FSM=IDLE; counters 0.
//  Inputs pass SYNC_STAGES flops; edge detect gives sclk_rise, sclk_fall, cs_fall, cs_rise, upd_rise.
//  Sampling on sclk_rise (mosi synced value); miso changes on sclk_fall.
//  Register byte lengths (4,3,2,1,4,2) by address; bytes MSB-first; register MSB byte first.
//  Instruction byte: bit7=1 read / 0 write, bits4:0 address, bits6:5 ignored.
//  FSM: IDLE -cs_fall-> INSTR.
//   INSTR: after 8th sclk_rise decode.
//    addr>5 -> err_p, DISCARD.
//    write -> WRITE.
//    read -> load tx_sr with shadow value left-aligned -> READ.
//   WRITE: collect len*8 bits into rx_sr; on final sclk_rise commit whole register to shadow, go to INSTR.
//   READ: each sclk_fall drives next tx_sr bit (first fall after instruction = MSB), miso_oe=1.
//    After len*8 data sclk_rise go to INSTR; miso_oe drops on next sclk_fall.
//   DISCARD: ignore all until cs_rise.
//  Multiple instructions in one n_cs frame are legal (back-to-back after each register completes).
//  cs_rise in any state: return to IDLE same clk; miso_oe=0, miso=0.
//   Partial byte/partial register is dropped; shadow unchanged.
//  upd_rise: all active <= shadow next clk; upd_p asserted that clk. Independent of n_cs state.
//  Same-clk write commit and upd_rise: active receives the newly committed value (bypass).
//  cs_fall while not IDLE (glitch) restarts at INSTR with bit counter 0.
//  Reads return shadow, not active. Widths not multiple of byte: none (ASF/POW full 16 b stored).
//  Latency: pin edge to internal action = SYNC_STAGES+1 clk.
// STRUCTURE
//  Package dds9952_pkg: register address localparams, byte-length table, reset values, FSM state encoding.
//  Sub-module sync_edge (SYNC_STAGES flop chain + rise/fall pulses), instantiated 4x.
//  Rest (FSM, bit/byte counters, rx/tx shifters, register file) flat in this module.
// TESTING
//  1 Write addr 4 (0x04) data 12 34 56 78, then io_update -> ftw_o=0x12345678, one upd_p; shadow visible before update, ftw_o unchanged.
//  2 Read addr 1 after reset (0x81) -> miso shifts 0x000018 MSB-first; miso_oe high exactly 24 sclk; err_p=0.
//  3 One frame: write addr 3 = 0xA5 then read addr 3 (0x03 A5 0x83 xx) -> read returns 0xA5.
//  4 Instruction 0x07 + 3 bytes -> err_p once, no register change, miso_oe stays 0; next frame works normally.
//  5 Write addr 0 with n_cs high after 2 of 4 data bytes -> cfr1 shadow still 0; subsequent read of addr 0 = 0.
//  6 io_update on same clk as final bit of write addr 5 = 0xBEEF -> pow_o=0xBEEF.
//  Loop-back: drive from spi_master_9952 (CLK_DIV_EVEN=8) with slave clk equal; all above pass.
//  Also: async reset mid-READ clears miso/miso_oe immediately.

Source files
------------

// File: rtl/dds9952_pkg.sv
// Shared definitions for the AD9952 serial-port responder: register map, lengths, FSM states.
package dds9952_pkg;

  localparam int unsigned ADDR_CFR1 = 0;
  localparam int unsigned ADDR_CFR2 = 1;
  localparam int unsigned ADDR_ASF  = 2;
  localparam int unsigned ADDR_ARR  = 3;
  localparam int unsigned ADDR_FTW  = 4;
  localparam int unsigned ADDR_POW  = 5;
  localparam int unsigned ADDR_MAX  = 5;

  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned WORD_W    = 32;

  localparam logic [23:0] CFR2_RST_DEF = 24'h000018;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INSTR,
    S_WRITE,
    S_READ,
    S_DISCARD
  } state_e;

  // Register length in bytes, indexed by address.
  function automatic logic [2:0] reg_bytes(input logic [ADDR_W-1:0] a);
    case (a)
      3'(ADDR_CFR1): reg_bytes = 3'd4;
      3'(ADDR_CFR2): reg_bytes = 3'd3;
      3'(ADDR_ASF):  reg_bytes = 3'd2;
      3'(ADDR_ARR):  reg_bytes = 3'd1;
      3'(ADDR_FTW):  reg_bytes = 3'd4;
      3'(ADDR_POW):  reg_bytes = 3'd2;
      default:       reg_bytes = 3'd1;
    endcase
  endfunction

  // Index of the final data bit of a register (len*8 - 1).
  function automatic logic [CNT_W-1:0] last_bit(input logic [ADDR_W-1:0] a);
    last_bit = CNT_W'((32'(reg_bytes(a)) << 3) - 32'd1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with registered history for rise/fall pulse generation.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q      = chain[STAGES-1];
  assign rise_c = q & ~prev;
  assign fall_c = ~q & prev;

endmodule

// File: rtl/spi_slave_9952.sv
// AD9952 serial-port stand-in: instruction decode, shadow/active register file, read-back on miso.
module spi_slave_9952
  import dds9952_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [23:0] CFR2_RST    = CFR2_RST_DEF
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        sclk,
  input  logic        n_cs,
  input  logic        mosi,
  input  logic        io_update,
  output logic        miso,
  output logic        miso_oe,
  output logic [31:0] cfr1_o,
  output logic [23:0] cfr2_o,
  output logic [15:0] asf_o,
  output logic [7:0]  arr_o,
  output logic [31:0] ftw_o,
  output logic [15:0] pow_o,
  output logic        upd_p,
  output logic        err_p
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, upd_rise, mosi_s;
  logic unused_sclk_q, unused_cs_q, unused_upd_q, unused_upd_fall;
  logic unused_mosi_rise, unused_mosi_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .n_rst(n_rst), .d(sclk),
    .q(unused_sclk_q), .rise_c(sclk_rise), .fall_c(sclk_fall));

  // n_cs idles high, so its chain resets high to avoid a spurious frame start.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .n_rst(n_rst), .d(n_cs),
    .q(unused_cs_q), .rise_c(cs_rise), .fall_c(cs_fall));

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .n_rst(n_rst), .d(mosi),
    .q(mosi_s), .rise_c(unused_mosi_rise), .fall_c(unused_mosi_fall));

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_upd (
    .clk(clk), .n_rst(n_rst), .d(io_update),
    .q(unused_upd_q), .rise_c(upd_rise), .fall_c(unused_upd_fall));

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   rx_q, rx_d, tx_q, tx_d, wr_data, rd_word;
  logic [4:0]          addr5;
  logic                miso_d, oe_d, err_d, wr_en;

  logic [31:0] sh_cfr1, sh_cfr1_d, sh_ftw, sh_ftw_d;
  logic [23:0] sh_cfr2, sh_cfr2_d;
  logic [15:0] sh_asf, sh_asf_d, sh_pow, sh_pow_d;
  logic [7:0]  sh_arr, sh_arr_d;

  // Address field of the instruction byte completing on this sclk_rise.
  assign addr5   = {rx_q[3:0], mosi_s};
  assign wr_data = {rx_q[WORD_W-2:0], mosi_s};

  // Shadow value of the addressed register, MSB-aligned for shifting out.
  always_comb begin
    rd_word = '0;
    case (addr5[2:0])
      3'(ADDR_CFR1): rd_word = sh_cfr1;
      3'(ADDR_CFR2): rd_word = {sh_cfr2, 8'h00};
      3'(ADDR_ASF):  rd_word = {sh_asf, 16'h0000};
      3'(ADDR_ARR):  rd_word = {sh_arr, 24'h000000};
      3'(ADDR_FTW):  rd_word = sh_ftw;
      3'(ADDR_POW):  rd_word = {sh_pow, 16'h0000};
      default:       rd_word = '0;
    endcase
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      err_p     <= 1'b0;
      upd_p     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso      <= miso_d;
      miso_oe   <= oe_d;
      err_p     <= err_d;
      upd_p     <= upd_rise;
    end
  end

  // Next-state logic: frame control has priority over bit traffic.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    addr_d    = addr_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso;
    oe_d      = miso_oe;
    err_d     = 1'b0;
    wr_en     = 1'b0;
    if (cs_rise) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      rx_d      = '0;
      miso_d    = 1'b0;
      oe_d      = 1'b0;
    end else if (cs_fall) begin
      state_d   = S_INSTR;
      bit_cnt_d = '0;
      rx_d      = '0;
      miso_d    = 1'b0;
      oe_d      = 1'b0;
    end else begin
      if (sclk_fall) begin
        if (state_q == S_READ) begin
          miso_d = tx_q[WORD_W-1];
          tx_d   = {tx_q[WORD_W-2:0], 1'b0};
          oe_d   = 1'b1;
        end else begin
          miso_d = 1'b0;
          oe_d   = 1'b0;
        end
      end
      if (sclk_rise) begin
        case (state_q)
          S_INSTR: begin
            rx_d      = wr_data;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d = '0;
              rx_d      = '0;
              if (addr5 > 5'(ADDR_MAX)) begin
                err_d   = 1'b1;
                state_d = S_DISCARD;
              end else begin
                addr_d = addr5[2:0];
                if (rx_q[6]) begin
                  tx_d    = rd_word;
                  state_d = S_READ;
                end else begin
                  state_d = S_WRITE;
                end
              end
            end
          end
          S_WRITE: begin
            rx_d      = wr_data;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == last_bit(addr_q)) begin
              wr_en     = 1'b1;
              bit_cnt_d = '0;
              rx_d      = '0;
              state_d   = S_INSTR;
            end
          end
          S_READ: begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == last_bit(addr_q)) begin
              bit_cnt_d = '0;
              state_d   = S_INSTR;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Shadow update; the committed value also feeds the active load (same-clk bypass).
  always_comb begin
    sh_cfr1_d = sh_cfr1;
    sh_cfr2_d = sh_cfr2;
    sh_asf_d  = sh_asf;
    sh_arr_d  = sh_arr;
    sh_ftw_d  = sh_ftw;
    sh_pow_d  = sh_pow;
    if (wr_en) begin
      case (addr_q)
        3'(ADDR_CFR1): sh_cfr1_d = wr_data;
        3'(ADDR_CFR2): sh_cfr2_d = wr_data[23:0];
        3'(ADDR_ASF):  sh_asf_d  = wr_data[15:0];
        3'(ADDR_ARR):  sh_arr_d  = wr_data[7:0];
        3'(ADDR_FTW):  sh_ftw_d  = wr_data;
        3'(ADDR_POW):  sh_pow_d  = wr_data[15:0];
        default: ;
      endcase
    end
  end

  // Shadow and active register file.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sh_cfr1 <= '0;       cfr1_o <= '0;
      sh_cfr2 <= CFR2_RST; cfr2_o <= CFR2_RST;
      sh_asf  <= '0;       asf_o  <= '0;
      sh_arr  <= '0;       arr_o  <= '0;
      sh_ftw  <= '0;       ftw_o  <= '0;
      sh_pow  <= '0;       pow_o  <= '0;
    end else begin
      sh_cfr1 <= sh_cfr1_d;
      sh_cfr2 <= sh_cfr2_d;
      sh_asf  <= sh_asf_d;
      sh_arr  <= sh_arr_d;
      sh_ftw  <= sh_ftw_d;
      sh_pow  <= sh_pow_d;
      if (upd_rise) begin
        cfr1_o <= sh_cfr1_d;
        cfr2_o <= sh_cfr2_d;
        asf_o  <= sh_asf_d;
        arr_o  <= sh_arr_d;
        ftw_o  <= sh_ftw_d;
        pow_o  <= sh_pow_d;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_9952.sv
// Directed bench for spi_slave_9952: bit-banged SPI master, hand-computed expectations.
module tb_spi_slave_9952;

  logic        clk = 1'b0;
  logic        n_rst, sclk, n_cs, mosi, io_update;
  logic        miso, miso_oe, upd_p, err_p;
  logic [31:0] cfr1_o, ftw_o;
  logic [23:0] cfr2_o;
  logic [15:0] asf_o, pow_o;
  logic [7:0]  arr_o;

  int n_tests = 0;
  int n_fail  = 0;
  int upd_total = 0;
  int err_total = 0;
  int oe_cnt = 0;
  int u0, e0;
  logic [7:0]  rx_byte = 8'h00;
  logic [23:0] rd24;
  logic        upd_on_last = 1'b0;

  always #5 clk = ~clk;

  spi_slave_9952 dut (
    .clk(clk), .n_rst(n_rst), .sclk(sclk), .n_cs(n_cs), .mosi(mosi),
    .io_update(io_update), .miso(miso), .miso_oe(miso_oe),
    .cfr1_o(cfr1_o), .cfr2_o(cfr2_o), .asf_o(asf_o), .arr_o(arr_o),
    .ftw_o(ftw_o), .pow_o(pow_o), .upd_p(upd_p), .err_p(err_p));

  // Pulse counters for upd_p / err_p.
  always @(posedge clk) begin
    if (upd_p) upd_total++;
    if (err_p) err_total++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One byte, MSB first, mode 0; miso sampled at each sclk rise.
  task automatic xfer(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      wait_clk(5);
      sclk = 1'b1;
      if (upd_on_last && i == 0) io_update = 1'b1;
      rx_byte = {rx_byte[6:0], miso};
      if (miso_oe) oe_cnt++;
      wait_clk(5);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    n_cs = 1'b0;
    wait_clk(5);
  endtask

  task automatic cs_high();
    wait_clk(2);
    n_cs = 1'b1;
    wait_clk(6);
  endtask

  initial begin
    n_rst = 1'b0; sclk = 1'b0; n_cs = 1'b1; mosi = 1'b0; io_update = 1'b0;
    wait_clk(3);
    chk("rst_miso",    32'(miso),    32'h0);
    chk("rst_miso_oe", 32'(miso_oe), 32'h0);
    chk("rst_upd_p",   32'(upd_p),   32'h0);
    chk("rst_err_p",   32'(err_p),   32'h0);
    chk("rst_cfr2",    32'(cfr2_o),  32'h18);
    chk("rst_ftw",     ftw_o,        32'h0);
    n_rst = 1'b1;
    wait_clk(5);

    // Write FTW, read shadow back before update, then io_update.
    cs_low();
    xfer(8'h04); xfer(8'h12); xfer(8'h34); xfer(8'h56); xfer(8'h78);
    cs_high();
    chk("t1_ftw_before_upd", ftw_o, 32'h0);
    cs_low();
    xfer(8'h84);
    xfer(8'h00); rd24[23:16] = rx_byte;
    xfer(8'h00); rd24[15:8]  = rx_byte;
    xfer(8'h00); rd24[7:0]   = rx_byte;
    xfer(8'h00);
    cs_high();
    chk("t1_shadow_read", {rd24, rx_byte}, 32'h12345678);
    u0 = upd_total;
    io_update = 1'b1;
    wait_clk(4);
    io_update = 1'b0;
    wait_clk(6);
    chk("t1_ftw_after_upd", ftw_o, 32'h12345678);
    chk("t1_upd_pulses", 32'(upd_total - u0), 32'd1);

    // Read CFR2 reset value.
    e0 = err_total;
    cs_low();
    xfer(8'h81);
    oe_cnt = 0;
    xfer(8'h00); rd24[23:16] = rx_byte;
    xfer(8'h00); rd24[15:8]  = rx_byte;
    xfer(8'h00); rd24[7:0]   = rx_byte;
    wait_clk(5);
    chk("t2_oe_dropped", 32'(miso_oe), 32'h0);
    cs_high();
    chk("t2_read_cfr2", 32'(rd24), 32'h000018);
    chk("t2_oe_sclks", 32'(oe_cnt), 32'd24);
    chk("t2_no_err", 32'(err_total - e0), 32'd0);

    // Write then read ARR within one frame.
    cs_low();
    xfer(8'h03); xfer(8'hA5); xfer(8'h83); xfer(8'h00);
    cs_high();
    chk("t3_read_arr", 32'(rx_byte), 32'hA5);
    chk("t3_arr_active_unchanged", 32'(arr_o), 32'h00);

    // Bad address: error pulse, rest of frame discarded.
    e0 = err_total;
    cs_low();
    oe_cnt = 0;
    xfer(8'h07); xfer(8'h11); xfer(8'h22); xfer(8'h33);
    cs_high();
    chk("t4_err_pulses", 32'(err_total - e0), 32'd1);
    chk("t4_oe_never", 32'(oe_cnt), 32'd0);
    chk("t4_ftw_kept", ftw_o, 32'h12345678);
    cs_low();
    xfer(8'h83); xfer(8'h00);
    cs_high();
    chk("t4_next_frame_read", 32'(rx_byte), 32'hA5);

    // Aborted write to CFR1 leaves shadow untouched.
    cs_low();
    xfer(8'h00); xfer(8'hDE); xfer(8'hAD);
    cs_high();
    cs_low();
    xfer(8'h80);
    xfer(8'h00); rd24[23:16] = rx_byte;
    xfer(8'h00); rd24[15:8]  = rx_byte;
    xfer(8'h00); rd24[7:0]   = rx_byte;
    xfer(8'h00);
    cs_high();
    chk("t5_cfr1_shadow", {rd24, rx_byte}, 32'h0);

    // io_update coincident with final bit of a POW write.
    u0 = upd_total;
    cs_low();
    xfer(8'h05); xfer(8'hBE);
    upd_on_last = 1'b1;
    xfer(8'hEF);
    upd_on_last = 1'b0;
    cs_high();
    io_update = 1'b0;
    wait_clk(6);
    chk("t6_pow_bypass", 32'(pow_o), 32'hBEEF);
    chk("t6_arr_active", 32'(arr_o), 32'hA5);
    chk("t6_cfr1_active", cfr1_o, 32'h0);
    chk("t6_upd_pulses", 32'(upd_total - u0), 32'd1);

    // Asynchronous reset in the middle of a read.
    cs_low();
    xfer(8'h85);
    wait_clk(4);
    chk("t7_oe_before_rst", 32'(miso_oe), 32'h1);
    chk("t7_miso_msb", 32'(miso), 32'h1);
    n_rst = 1'b0;
    #1;
    chk("t7_rst_miso", 32'(miso), 32'h0);
    chk("t7_rst_oe", 32'(miso_oe), 32'h0);
    chk("t7_rst_pow", 32'(pow_o), 32'h0);
    chk("t7_rst_cfr2", 32'(cfr2_o), 32'h18);
    n_cs = 1'b1;
    wait_clk(3);
    n_rst = 1'b1;
    wait_clk(6);
    chk("t7_oe_after_rst", 32'(miso_oe), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
